// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared occupancy encodings, read-latency constants and read-admission helper
package fifo_rd_stream_pkg;

  // Legal values of the upstream FIFO read latency.
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // A new read may launch only if, after this cycle's pop, at most one slot is
  // already committed (buffered or still arriving), so its push always has room.
  function automatic logic rd_allowed(input logic [1:0] occ,
                                      input logic       inflight,
                                      input logic       pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return committed <= 3'd1;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - 2-entry in-order stream buffer with registered output
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  pop,
  output logic [1:0]            occ
);

  occ_e                  state_q;
  occ_e                  state_d;
  logic [DATA_WIDTH-1:0] mem0;
  logic [DATA_WIDTH-1:0] mem1;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  push_ok;

  assign m_valid = (state_q != OCC_EMPTY);
  assign pop     = m_valid && m_ready;
  // A push into a full buffer without a matching pop would overwrite the oldest
  // beat; the read-admission logic upstream never allows it, so it is dropped.
  assign push_ok = push && ((state_q != OCC_TWO) || pop);
  assign occ     = state_q;
  // Both entries are registers, so the head is a register-to-port mux only.
  assign m_data  = rd_ptr ? mem1 : mem0;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  // Occupancy next state from push/pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (push_ok) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push_ok && !pop)      state_d = OCC_TWO;
        else if (!push_ok && pop) state_d = OCC_EMPTY;
      end
      OCC_TWO:   if (pop && !push_ok) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Entry storage and ring pointers; head only moves on pop so m_data holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_ok) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - converts an upstream FIFO read port into a valid/ready stream
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occ,
  output logic [15:0]           beat_cnt
);

  logic inflight;
  logic push;
  logic pop;

  // Reads stay off during reset so no request escapes while state is being cleared.
  assign fifo_r_en = rst_n && !fifo_empty && rd_allowed(occ, inflight, pop);

  // With combinational FIFO data the word is captured in the request cycle;
  // with registered data it arrives, and is captured, one cycle later.
  assign push = (RD_LAT == RD_LAT_REG) ? inflight : fifo_r_en;

  // Track a read launched last cycle whose data is still arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= (RD_LAT == RD_LAT_REG) ? fifo_r_en : 1'b0;
  end

  // Count delivered beats, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   beat_cnt <= 16'h0000;
    else if (pop) beat_cnt <= beat_cnt + 16'h0001;
  end

  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_rdata),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .pop       (pop),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream, RD_LAT 0 and 1 instances
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          fifo_empty [2];
  logic [DW-1:0] fifo_rdata [2];
  logic          fifo_r_en  [2];
  logic          m_valid    [2];
  logic [DW-1:0] m_data     [2];
  logic          m_ready    [2];
  logic [1:0]    occ        [2];
  logic [15:0]   beat_cnt   [2];

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[0]), .fifo_rdata(fifo_rdata[0]),
    .fifo_r_en(fifo_r_en[0]), .m_valid(m_valid[0]), .m_data(m_data[0]),
    .m_ready(m_ready[0]), .occ(occ[0]), .beat_cnt(beat_cnt[0]));

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[1]), .fifo_rdata(fifo_rdata[1]),
    .fifo_r_en(fifo_r_en[1]), .m_valid(m_valid[1]), .m_data(m_data[1]),
    .m_ready(m_ready[1]), .occ(occ[1]), .beat_cnt(beat_cnt[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Upstream FIFO contents not yet read, and words read but not yet delivered.
  logic [DW-1:0] src_q [2][$];
  logic [DW-1:0] exp_q [2][$];

  logic        ren_s      [2];
  logic        infl_m     [2];
  logic        wait_first [2];
  int          fall_cyc   [2];
  int          ren_count  [2];
  int          lat_seen   [2];
  logic [15:0] model_cnt  [2];
  int          beats      [2];
  int          first_cyc  [2];
  int          last_cyc   [2];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at cycle %0d", name, idx, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Upstream FIFO model: act on the read request seen during the cycle that just ended.
  always @(posedge clk) begin
    logic          prev_empty;
    logic [DW-1:0] w;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ren_s[i] && src_q[i].size() > 0) begin
        w = src_q[i].pop_front();
        exp_q[i].push_back(w);
        if (i == 1) fifo_rdata[1] = w;
      end
      infl_m[i]     = (i == 1) ? ren_s[i] : 1'b0;
      prev_empty    = fifo_empty[i];
      fifo_empty[i] = (src_q[i].size() == 0);
      if (prev_empty && !fifo_empty[i] && rst_n && exp_q[i].size() == 0) begin
        wait_first[i] = 1'b1;
        fall_cyc[i]   = cyc;
      end
    end
    fifo_rdata[0] = (src_q[0].size() > 0) ? src_q[0][0] : '0;
  end

  // Sample read requests and first-beat latency mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ren_s[i] = fifo_r_en[i];
      if (!rst_n) begin
        chk("ren_in_reset", i, fifo_r_en[i], 1'b0);
      end else begin
        if (fifo_r_en[i]) ren_count[i]++;
        if (wait_first[i] && m_valid[i]) begin
          chk("first_latency", i, cyc - fall_cyc[i], i + 1);
          lat_seen[i]++;
          wait_first[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: compare the DUT against the outstanding-word model and pop on delivery.
  always @(negedge clk) begin
    int   outstanding;
    int   mocc;
    logic mpop;
    logic eren;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        outstanding = exp_q[i].size();
        mocc        = outstanding - int'(infl_m[i]);
        chk("occ", i, occ[i], mocc);
        chk("m_valid", i, m_valid[i], mocc > 0);
        mpop = (mocc > 0) && m_ready[i];
        eren = !fifo_empty[i] && ((outstanding - int'(mpop)) <= 1);
        chk("fifo_r_en", i, fifo_r_en[i], eren);
        chk("beat_cnt", i, beat_cnt[i], model_cnt[i]);
        if (m_valid[i]) begin
          if (outstanding == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat[%0d]: got %0h expected no beat at cycle %0d", i, m_data[i], cyc);
          end else begin
            chk("m_data", i, m_data[i], exp_q[i][0]);
            if (m_ready[i]) begin
              void'(exp_q[i].pop_front());
              model_cnt[i]++;
              if (beats[i] == 0) first_cyc[i] = cyc;
              last_cyc[i] = cyc;
              beats[i]++;
            end
          end
        end
      end
    end
  end

  task automatic set_ready(input logic r0, input logic r1);
    m_ready[0] = r0;
    m_ready[1] = r1;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      beats[i] = 0;
      first_cyc[i] = 0;
      last_cyc[i] = 0;
    end
  endtask

  // Entered at posedge+2; leaves at posedge+2 with both instances idle.
  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(src_q[0].size() == 0 && exp_q[0].size() == 0 && fifo_empty[0] &&
             src_q[1].size() == 0 && exp_q[1].size() == 0 && fifo_empty[1]) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout[0]: got %0d cycles expected below %0d", n, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      infl_m[i] = 1'b0;
      ren_s[i] = 1'b0;
      model_cnt[i] = 16'h0000;
      wait_first[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_m_valid", i, m_valid[i], 1'b0);
      chk("rst_occ", i, occ[i], 2'd0);
      chk("rst_m_data", i, m_data[i], '0);
      chk("rst_beat_cnt", i, beat_cnt[i], 16'h0000);
      chk("rst_r_en", i, fifo_r_en[i], 1'b0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    int p1;
    int n;
    logic [15:0] k16;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = 1'b1;
      fifo_rdata[i] = '0;
      m_ready[i] = 1'b0;
      ren_s[i] = 1'b0;
      infl_m[i] = 1'b0;
      wait_first[i] = 1'b0;
      fall_cyc[i] = 0;
      ren_count[i] = 0;
      lat_seen[i] = 0;
      model_cnt[i] = 16'h0000;
    end
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    do_reset();

    // Preloaded 0x11..0x18 with m_ready high: eight back-to-back beats.
    set_ready(1'b1, 1'b1);
    clear_stats();
    for (int v = 8'h11; v <= 8'h18; v++) begin
      src_q[0].push_back(DW'(v));
      src_q[1].push_back(DW'(v));
    end
    wait_drain(100);
    for (int i = 0; i < 2; i++) begin
      chk("burst_beats", i, beats[i], 8);
      chk("burst_span", i, last_cyc[i] - first_cyc[i], 7);
      chk("burst_beat_cnt", i, beat_cnt[i], 16'd8);
      chk("burst_occ", i, occ[i], 2'd0);
    end
    chk("burst_lat_seen", 1, lat_seen[1], 1);

    // Backpressure: exactly two reads, buffer full, head word held.
    set_ready(1'b0, 1'b0);
    p0 = ren_count[0];
    p1 = ren_count[1];
    for (int v = 8'h21; v <= 8'h24; v++) begin
      src_q[0].push_back(DW'(v));
      src_q[1].push_back(DW'(v));
    end
    repeat (10) @(posedge clk);
    #2;
    chk("stall_reads", 0, ren_count[0] - p0, 2);
    chk("stall_reads", 1, ren_count[1] - p1, 2);
    for (int i = 0; i < 2; i++) begin
      chk("stall_occ", i, occ[i], 2'd2);
      chk("stall_head", i, m_data[i], 8'h21);
    end
    set_ready(1'b1, 1'b1);
    wait_drain(100);

    // Single word on the combinational-latency instance.
    p0 = lat_seen[0];
    src_q[0].push_back(8'hA5);
    wait_drain(50);
    chk("single_lat_seen", 0, lat_seen[0] - p0, 1);

    // Reset while the buffers are full, then mid-stream.
    set_ready(1'b0, 1'b0);
    for (int v = 0; v < 3; v++) begin
      src_q[0].push_back(DW'(8'h30 + v));
      src_q[1].push_back(DW'(8'h30 + v));
    end
    repeat (6) @(posedge clk);
    #2;
    chk("pre_reset_occ", 1, occ[1], 2'd2);
    do_reset();
    set_ready(1'b1, 1'b1);
    wait_drain(100);
    for (int v = 0; v < 20; v++) begin
      src_q[0].push_back(DW'($urandom));
      src_q[1].push_back(DW'($urandom));
    end
    repeat (5) @(posedge clk);
    #2;
    do_reset();
    wait_drain(100);

    // Toggling then random backpressure with random supply.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 2; i++) begin
        if (k < 400) m_ready[i] = k[0];
        else         m_ready[i] = 1'($urandom_range(0, 1));
        if (src_q[i].size() < 3 && $urandom_range(0, 3) != 0) src_q[i].push_back(DW'($urandom));
      end
    end
    set_ready(1'b1, 1'b1);
    wait_drain(100);

    // Stream 65536 beats so beat_cnt wraps back to zero.
    do_reset();
    set_ready(1'b1, 1'b1);
    clear_stats();
    p0 = 0;
    p1 = 0;
    n = 0;
    while ((p0 < 65536 || p1 < 65536) && n < 80000) begin
      @(posedge clk); #2;
      n++;
      while (src_q[0].size() < 4 && p0 < 65536) begin
        k16 = 16'(p0);
        src_q[0].push_back(k16[7:0] ^ k16[15:8]);
        p0++;
      end
      while (src_q[1].size() < 4 && p1 < 65536) begin
        k16 = 16'(p1);
        src_q[1].push_back(k16[7:0] + k16[15:8]);
        p1++;
      end
    end
    wait_drain(100);
    for (int i = 0; i < 2; i++) begin
      chk("wrap_beats", i, beats[i], 65536);
      chk("wrap_beat_cnt", i, beat_cnt[i], 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
